mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported memory between instruction fetch (IF) and load/store (LS) of the RV32I core.
//  Accepts one request at a time over valid/ready, issues it to memory, routes the response back to its owner.
//  Fixed priority LS > IF, with a starvation limit that guarantees IF progress. One outstanding transaction.
// PARAMETERS
//  ADDR_W        32  address width
//  DATA_W        32  data width
//  STARVE_LIMIT  4   consecutive LS grants while IF waits before IF is forced (1..15)
// PORTS
//  clk            in   1       clock
//  reset          in   1       synchronous, active-low
//  if_req_valid   in   1       fetch request
//  if_req_ready   out  1       fetch request accepted this cycle
//  if_addr        in   ADDR_W  fetch address
//  if_rsp_valid   out  1       fetch data valid (1-cycle pulse)
//  if_rsp_data    out  DATA_W  fetched instruction
//  ls_req_valid   in   1       load/store request
//  ls_req_ready   out  1       load/store request accepted this cycle
//  ls_we          in   1       1=store, 0=load
//  ls_addr        in   ADDR_W  load/store address
//  ls_wdata       in   DATA_W  store data
//  ls_wstrb       in   4       store byte enables
//  ls_rsp_valid   out  1       load data / store ack (1-cycle pulse)
//  ls_rsp_data    out  DATA_W  load data; 0 for store ack
//  mem_req_valid  out  1       request to memory
//  mem_req_ready  in   1       memory accepts request
//  mem_we         out  1       write enable
//  mem_addr       out  ADDR_W  address
//  mem_wdata      out  DATA_W  write data
//  mem_wstrb      out  4       byte enables; 0 for reads
//  mem_rsp_valid  in   1       memory response (reads and writes)
//  mem_rsp_data   in   DATA_W  read data
//  busy           out  1       state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; all valid/ready outputs 0; mem_addr/wdata/wstrb/we, rsp data 0; owner=IF; starve_cnt=0.
//  FSM: IDLE -> REQ on grant; REQ -> WAIT on mem_req_valid&&mem_req_ready; WAIT -> IDLE on mem_rsp_valid.
//  IDLE grant (cycle N): if both valid, LS wins unless starve_cnt==STARVE_LIMIT, then IF wins.
//   Winner's *_req_ready=1 combinationally in N only; request fields captured into mem_* regs at N.
//  starve_cnt: +1 on LS grant while if_req_valid=1; cleared on IF grant or LS grant with if_req_valid=0; saturates.
//  REQ: mem_req_valid=1 from N+1, mem_* held stable until mem_req_ready; both *_req_ready=0.
//  WAIT: owner's *_rsp_valid pulses 1 cycle after mem_rsp_valid, data registered; state=IDLE same cycle,
//   new grant possible that cycle. Min turnaround: accept N, mem req N+1, mem rsp N+2, owner rsp N+3.
//  mem_rsp_valid outside WAIT is ignored (no rsp pulse). Non-owner rsp_valid never asserts.
//  Reset mid-transaction: everything to reset values next edge; pending request dropped, no response.
// CONFIGURATION
//  MEM_ARB_PERF_EN defined: adds outputs perf_if_grants[31:0], perf_ls_grants[31:0], perf_stall_cycles[31:0]
//   (cycles with any *_req_valid=1 and no grant); all reset to 0, wrap modulo 2^32.
//  Undefined: those ports and counters absent; arbitration behaviour identical.
// STRUCTURE
//  core_mem_pkg: arb_state_t {IDLE,REQ,WAIT}, owner_t {OWN_IF,OWN_LS}, WSTRB_W=4, STARVE_CNT_W=4.
//  Sub-module mem_arb_perf_cnt (three counters) instantiated only under MEM_ARB_PERF_EN.
// TESTING
//  1 IF only, addr 0x8, mem_req_ready=1, rsp 0x00700113 next cycle -> ready N, mem_addr 0x8 we=0 N+1, if_rsp N+3.
//  2 IF load + LS store 0x20/0x7/wstrb 0xF same cycle -> LS granted first (mem_we=1), IF granted at LS response.
//  3 STARVE_LIMIT=2, both valid continuously -> grant order LS,LS,IF,LS,LS,IF.
//  4 mem_req_ready low 5 cycles in REQ -> mem_* stable, busy=1, no *_req_ready, no new grant.
//  5 reset low in WAIT, then mem_rsp_valid -> next cycle IDLE, mem_req_valid=0, no rsp pulse to IF or LS.
//  6 MEM_ARB_PERF_EN, 3 IF + 2 LS transactions -> perf_if_grants=3, perf_ls_grants=2.

Source files
------------

// File: rtl/core_mem_pkg.sv
// Shared types for the IF/LS memory port arbiter.
// Arbiter states, request owner encoding and starvation counter helper.
package core_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } owner_t;

    localparam int WSTRB_W      = 4;
    localparam int STARVE_CNT_W = 4;

    localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = '1;

    // IF waiting behind an LS grant is the only thing that builds up starvation.
    function automatic logic [STARVE_CNT_W-1:0] starve_next(
        input logic [STARVE_CNT_W-1:0] cnt,
        input logic                    grant_if,
        input logic                    grant_ls,
        input logic                    if_valid
    );
        logic [STARVE_CNT_W-1:0] res;
        res = cnt;
        if (grant_if) begin
            res = '0;
        end else if (grant_ls) begin
            if (!if_valid) begin
                res = '0;
            end else if (cnt != STARVE_MAX) begin
                res = cnt + 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_arb_perf_cnt.sv
// Grant and stall event counters for the memory port arbiter.
// All counters clear on reset and wrap modulo 2^32.
module mem_arb_perf_cnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_grant,
    input  logic        ls_grant,
    input  logic        stall,
    output logic [31:0] perf_if_grants,
    output logic [31:0] perf_ls_grants,
    output logic [31:0] perf_stall_cycles
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_if_grants    <= '0;
            perf_ls_grants    <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (if_grant) begin
                perf_if_grants <= perf_if_grants + 32'd1;
            end
            if (ls_grant) begin
                perf_ls_grants <= perf_ls_grants + 32'd1;
            end
            if (stall) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: LS over IF with an IF starvation limit.
// Define MEM_ARB_PERF_EN to add the perf_* grant/stall counters.
module mem_port_arbiter
    import core_mem_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               if_req_valid,
    output logic               if_req_ready,
    input  logic [ADDR_W-1:0]  if_addr,
    output logic               if_rsp_valid,
    output logic [DATA_W-1:0]  if_rsp_data,
    input  logic               ls_req_valid,
    output logic               ls_req_ready,
    input  logic               ls_we,
    input  logic [ADDR_W-1:0]  ls_addr,
    input  logic [DATA_W-1:0]  ls_wdata,
    input  logic [WSTRB_W-1:0] ls_wstrb,
    output logic               ls_rsp_valid,
    output logic [DATA_W-1:0]  ls_rsp_data,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic [WSTRB_W-1:0] mem_wstrb,
    input  logic               mem_rsp_valid,
    input  logic [DATA_W-1:0]  mem_rsp_data,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0]        perf_if_grants,
    output logic [31:0]        perf_ls_grants,
    output logic [31:0]        perf_stall_cycles,
`endif
    output logic               busy
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT =
        STARVE_CNT_W'(STARVE_LIMIT);

    arb_state_t              state;
    arb_state_t              state_nxt;
    owner_t                  owner;
    logic [STARVE_CNT_W-1:0] starve_cnt;
    logic                    grant_if;
    logic                    grant_ls;
    logic                    if_forced;
    logic                    rsp_take;

    assign if_forced = if_req_valid && (starve_cnt == LIMIT);
    assign rsp_take  = (state == WAIT) && mem_rsp_valid;

    // Grants only in IDLE and never while reset is held.
    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_ls  = 1'b0;
        unique case (state)
            IDLE: begin
                if (reset) begin
                    if (ls_req_valid && !if_forced) begin
                        grant_ls = 1'b1;
                    end else if (if_req_valid) begin
                        grant_if = 1'b1;
                    end
                end
                if (grant_if || grant_ls) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign if_req_ready  = grant_if;
    assign ls_req_ready  = grant_ls;
    assign mem_req_valid = (state == REQ);
    assign busy          = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_next(starve_cnt, grant_if,
                                      grant_ls, if_req_valid);
            if (grant_ls) begin
                owner <= OWN_LS;
            end else if (grant_if) begin
                owner <= OWN_IF;
            end
        end
    end

    // Request fields are frozen from grant until the memory accepts.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else if (grant_ls) begin
            mem_we    <= ls_we;
            mem_addr  <= ls_addr;
            mem_wdata <= ls_wdata;
            mem_wstrb <= ls_we ? ls_wstrb : '0;
        end else if (grant_if) begin
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if_rsp_valid <= 1'b0;
            ls_rsp_valid <= 1'b0;
            if_rsp_data  <= '0;
            ls_rsp_data  <= '0;
        end else begin
            if_rsp_valid <= rsp_take && (owner == OWN_IF);
            ls_rsp_valid <= rsp_take && (owner == OWN_LS);
            if (rsp_take && owner == OWN_IF) begin
                if_rsp_data <= mem_rsp_data;
            end
            if (rsp_take && owner == OWN_LS) begin
                ls_rsp_data <= mem_we ? '0 : mem_rsp_data;
            end
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic stall;

    assign stall = (if_req_valid || ls_req_valid)
                && !(grant_if || grant_ls);

    mem_arb_perf_cnt u_perf (
        .clk               (clk),
        .reset             (reset),
        .if_grant          (grant_if),
        .ls_grant          (grant_ls),
        .stall             (stall),
        .perf_if_grants    (perf_if_grants),
        .perf_ls_grants    (perf_ls_grants),
        .perf_stall_cycles (perf_stall_cycles)
    );
`endif

endmodule
